// File: rtl/upc_entry.sv
// Three-press UPC code entry: synchronizes a push-button and bit switch, assembles
// a 3-bit code MSB first, and aborts a partial entry after an idle timeout.
module upc_entry #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic       bit_in,
    input  logic       clear,
    output logic [2:0] upc,
    output logic       upc_valid,
    output logic       known,
    output logic       busy,
    output logic       abort
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT1 = 2'd1,
        GOT2 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             key_s1;
    logic             key_s2;
    logic             key_prev;
    logic             bit_s1;
    logic             bit_s2;
    logic             press;
    logic             b2;
    logic             b2_nxt;
    logic             b1;
    logic             b1_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       upc_nxt;
    logic             valid_nxt;
    logic             known_nxt;
    logic             abort_nxt;

    function automatic logic is_known(input logic [2:0] code);
        case (code)
            3'b010, 3'b111: is_known = 1'b0;
            default:        is_known = 1'b1;
        endcase
    endfunction

    // Idle level of key_n is high, so the key flops reset to 1 to avoid a false press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_prev <= 1'b1;
            bit_s1   <= 1'b0;
            bit_s2   <= 1'b0;
        end else if (clear) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_prev <= 1'b1;
            bit_s1   <= 1'b0;
            bit_s2   <= 1'b0;
        end else begin
            key_s1   <= key_n;
            key_s2   <= key_s1;
            key_prev <= key_s2;
            bit_s1   <= bit_in;
            bit_s2   <= bit_s1;
        end
    end

    assign press = key_prev & ~key_s2;
    assign busy  = (state == GOT1) || (state == GOT2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        b2_nxt    = b2;
        b1_nxt    = b1;
        cnt_nxt   = cnt;
        upc_nxt   = upc;
        valid_nxt = upc_valid;
        known_nxt = known;
        abort_nxt = 1'b0;
        case (state)
            IDLE, DONE: begin
                cnt_nxt = '0;
                if (press) begin
                    state_nxt = GOT1;
                    b2_nxt    = bit_s2;
                    b1_nxt    = 1'b0;
                end
            end
            GOT1, GOT2: begin
                // A press in the terminal-count cycle still advances the entry.
                if (press) begin
                    cnt_nxt = '0;
                    if (state == GOT1) begin
                        state_nxt = GOT2;
                        b1_nxt    = bit_s2;
                    end else begin
                        state_nxt = DONE;
                        upc_nxt   = {b2, b1, bit_s2};
                        valid_nxt = 1'b1;
                        known_nxt = is_known({b2, b1, bit_s2});
                        b2_nxt    = 1'b0;
                        b1_nxt    = 1'b0;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_nxt = upc_valid ? DONE : IDLE;
                    cnt_nxt   = '0;
                    b2_nxt    = 1'b0;
                    b1_nxt    = 1'b0;
                    abort_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b2        <= 1'b0;
            b1        <= 1'b0;
            cnt       <= '0;
            upc       <= 3'b000;
            upc_valid <= 1'b0;
            known     <= 1'b0;
            abort     <= 1'b0;
        end else if (clear) begin
            b2        <= 1'b0;
            b1        <= 1'b0;
            cnt       <= '0;
            upc       <= 3'b000;
            upc_valid <= 1'b0;
            known     <= 1'b0;
            abort     <= 1'b0;
        end else begin
            b2        <= b2_nxt;
            b1        <= b1_nxt;
            cnt       <= cnt_nxt;
            upc       <= upc_nxt;
            upc_valid <= valid_nxt;
            known     <= known_nxt;
            abort     <= abort_nxt;
        end
    end

endmodule
